// File: rtl/mvu_pkg.sv
// Shared types for the MVU RAM read streamer.
// FSM encoding and default output FIFO depth.
package mvu_pkg;

  typedef enum logic [1:0] {
    STRM_IDLE  = 2'd0,
    STRM_RUN   = 2'd1,
    STRM_DRAIN = 2'd2
  } strm_state_t;

  localparam int STRM_DEPTH = 4;

endpackage

// File: rtl/mvu_stream_fifo.sv
// Synchronous FIFO buffering RAM words between capture and the MVU stream.
// Head data is the oldest entry; occ counts stored entries.
module mvu_stream_fifo #(
  parameter int WIDTH = 2049,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [AW:0]      occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mvu_ram_streamer.sv
// Read-side RAM sequencer: walks an address range, captures each word
// the cycle after issue and streams it out through a small FIFO.
module mvu_ram_streamer
  import mvu_pkg::*;
#(
  parameter int BDADDR = 12,
  parameter int BDWORD = 2048,
  parameter int DEPTH  = STRM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BDADDR-1:0] base_addr,
  input  logic [BDADDR:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [BDADDR-1:0] ram_rd_addr,
  input  logic [BDWORD-1:0] ram_rd_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BDWORD-1:0] out_word,
  output logic              out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  strm_state_t       state;
  logic [BDADDR:0]   rem;
  logic [BDADDR-1:0] next_addr;
  logic [BDADDR-1:0] last_addr;
  logic              inflight;
  logic              inflight_last;
  logic [AW:0]       occ;
  logic [BDWORD:0]   head;
  logic              out_pop;
  logic              issue;
  logic              rem_one;
  logic              head_last;
  logic [CW-1:0]     credit_used;
  logic [CW-1:0]     credit_cap;

  assign out_valid = occ != '0;
  assign out_pop   = out_valid && out_ready;
  assign head_last = head[BDWORD];
  assign out_word  = out_valid ? head[BDWORD-1:0] : '0;
  assign out_last  = out_valid && head_last;

  // A returning word must always find a free slot, counting this cycle's pop.
  assign credit_used = CW'(occ) + CW'(inflight);
  assign credit_cap  = CW'(DEPTH) + CW'(out_pop);
  assign issue       = (state == STRM_RUN) && (credit_used < credit_cap);
  assign rem_one     = rem == {{BDADDR{1'b0}}, 1'b1};

  assign ram_rd_en   = issue;
  assign ram_rd_addr = issue ? next_addr : last_addr;
  assign busy        = state != STRM_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STRM_IDLE;
      rem           <= '0;
      next_addr     <= '0;
      last_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && rem_one;
      if (issue) begin
        last_addr <= next_addr;
        next_addr <= next_addr + 1'b1;
        rem       <= rem - 1'b1;
      end
      unique case (state)
        STRM_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state     <= STRM_RUN;
              next_addr <= base_addr;
              rem       <= length;
            end
          end
        end
        STRM_RUN: begin
          if (issue && rem_one) begin
            state <= STRM_DRAIN;
          end
        end
        STRM_DRAIN: begin
          if (out_pop && head_last) begin
            state <= STRM_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= STRM_IDLE;
      endcase
    end
  end

  mvu_stream_fifo #(
    .WIDTH (BDWORD + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, ram_rd_word}),
    .pop       (out_pop),
    .occ       (occ),
    .head      (head)
  );

endmodule

// File: tb/tb_mvu_ram_streamer.sv
// Self-checking bench for mvu_ram_streamer: randomized backpressure
// against a transaction-level model of expected issues and beats.
module tb_mvu_ram_streamer;

  localparam int BDADDR = 12;
  localparam int BDWORD = 2048;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [BDADDR-1:0] a;
    bit                last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [BDADDR-1:0] base_addr;
  logic [BDADDR:0]   length;
  logic              busy;
  logic              done;
  logic              ram_rd_en;
  logic [BDADDR-1:0] ram_rd_addr;
  logic [BDWORD-1:0] ram_rd_word;
  logic              out_valid;
  logic              out_ready;
  logic [BDWORD-1:0] out_word;
  logic              out_last;

  int compared = 0;
  int mismatched = 0;

  beat_t             exp_q[$];
  logic [BDADDR-1:0] iss_q[$];
  logic [BDADDR-1:0] iss_log[$];
  bit                mbusy = 0;
  bit                done_pend = 0;
  bit                prev_stall = 0;
  logic [BDWORD:0]   prev_hold;
  int                outstanding = 0;
  int                beats = 0;
  int                cyc = 0;
  int                start_cyc = 0;
  int                lat = -1;
  bit                lat_arm = 0;
  int                first_beat_cyc = 0;
  int                last_beat_cyc = 0;
  logic [31:0]       first_word_lo;
  int                rmode = 0;
  beat_t             e;
  bit                was_busy;

  always #5 clk = ~clk;

  mvu_ram_streamer #(
    .BDADDR (BDADDR),
    .BDWORD (BDWORD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_word (ram_rd_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_last    (out_last)
  );

  function automatic logic [BDWORD-1:0] gen_word(input logic [BDADDR-1:0] a);
    logic [BDWORD-1:0] w;
    for (int i = 0; i < BDWORD / 32; i++) begin
      w[i*32 +: 32] = {a, 4'h5, 8'(i), a[3:0], 4'hC};
    end
    return w;
  endfunction

  // RAM output register is rewritten every cycle; garbage when not read.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_word <= gen_word(ram_rd_addr);
    else           ram_rd_word <= {64{32'($urandom())}};
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [BDWORD:0] act,
                         input logic [BDWORD:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got last=%0b lo=%016h expected last=%0b lo=%016h (t=%0t)",
               name, act[BDWORD], act[63:0], exp[BDWORD], exp[63:0], $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      iss_q.delete();
      mbusy       = 0;
      done_pend   = 0;
      prev_stall  = 0;
      outstanding = 0;
      lat_arm     = 0;
    end else begin
      was_busy = mbusy;
      check("done", 64'(done), 64'(done_pend));
      check("busy", 64'(busy), 64'(mbusy));
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check_w("hold_word", {out_last, out_word}, prev_hold);
      end
      if (ram_rd_en) begin
        if (iss_q.size() == 0) check("spurious_rd_en", 64'd1, 64'd0);
        else check("rd_addr", 64'(ram_rd_addr), 64'(iss_q.pop_front()));
        iss_log.push_back(ram_rd_addr);
        outstanding++;
      end
      check("spurious_valid", 64'(out_valid && exp_q.size() == 0), 64'd0);
      if (out_valid && lat_arm) begin
        lat     = cyc - start_cyc;
        lat_arm = 0;
      end
      done_pend = 0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_w("beat", {out_last, out_word}, {e.last, gen_word(e.a)});
        outstanding--;
        if (beats == 0) begin
          first_beat_cyc = cyc;
          first_word_lo  = out_word[31:0];
        end
        last_beat_cyc = cyc;
        beats++;
        if (e.last) begin
          done_pend = 1;
          mbusy     = 0;
        end
      end
      check("occupancy", 64'(outstanding <= DEPTH), 64'd1);
      prev_stall = out_valid && !out_ready;
      prev_hold  = {out_last, out_word};
      if (start && !was_busy) begin
        iss_log.delete();
        beats     = 0;
        start_cyc = cyc;
        lat       = -1;
        if (length == 0) begin
          done_pend = 1;
        end else begin
          mbusy   = 1;
          lat_arm = 1;
          for (int k = 0; k < int'(length); k++) begin
            exp_q.push_back('{a: base_addr + BDADDR'(k), last: (k == int'(length) - 1)});
            iss_q.push_back(base_addr + BDADDR'(k));
          end
        end
      end
    end
  end

  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        out_ready = 1'b1;
        k = 0;
      end else begin
        out_ready = (k >= 5 && k < 15) ? 1'b0 : 1'($urandom_range(0, 1));
        k++;
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(ram_rd_en), 64'd0);
    check("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_word", 64'(out_word != '0), 64'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mbusy || exp_q.size() > 0 || done_pend) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic launch(input logic [BDADDR-1:0] b, input logic [BDADDR:0] l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [BDADDR-1:0] b, input logic [BDADDR:0] l,
                     input int budget);
    launch(b, l);
    wait_idle(budget);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    run(12'h010, 13'd8, 200);
    check("basic_latency", 64'(lat), 64'd3);
    check("basic_beats", 64'(beats), 64'd8);
    check("basic_back2back", 64'(last_beat_cyc - first_beat_cyc), 64'd7);
    check("basic_first_word", 64'(first_word_lo), 64'h0105000C);
    check("basic_first_addr", 64'(iss_log[0]), 64'h010);
    check("basic_last_addr", 64'(iss_log[7]), 64'h017);

    run(12'hFFE, 13'd4, 200);
    check("wrap_cnt", 64'(iss_log.size()), 64'd4);
    check("wrap_a0", 64'(iss_log[0]), 64'hFFE);
    check("wrap_a1", 64'(iss_log[1]), 64'hFFF);
    check("wrap_a2", 64'(iss_log[2]), 64'h000);
    check("wrap_a3", 64'(iss_log[3]), 64'h001);

    rmode = 1;
    for (int t = 0; t < 4; t++) begin
      run(BDADDR'($urandom), 13'd16, 400);
      check("bp_beats", 64'(beats), 64'd16);
    end
    rmode = 0;

    run(BDADDR'($urandom), 13'd0, 50);
    check("zero_reads", 64'(iss_log.size()), 64'd0);
    check("zero_beats", 64'(beats), 64'd0);

    run(BDADDR'($urandom), 13'd1, 50);
    check("one_beats", 64'(beats), 64'd1);

    run(BDADDR'($urandom), 13'd4096, 6000);
    check("full_reads", 64'(iss_log.size()), 64'd4096);
    check("full_beats", 64'(beats), 64'd4096);

    rmode = 1;
    launch(12'h200, 13'd12);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 12'h555;
    length    = 13'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(400);
    check("ignored_beats", 64'(beats), 64'd12);
    check("ignored_first", 64'(iss_log[0]), 64'h200);
    rmode = 0;

    launch(BDADDR'($urandom), 13'd16);
    for (int n = 0; n < 100 && beats < 4; n++) @(posedge clk);
    check("mid_reached", 64'(beats), 64'd4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    run(12'h100, 13'd2, 100);
    check("post_rst_beats", 64'(beats), 64'd2);
    check("post_rst_a0", 64'(iss_log[0]), 64'h100);
    check("post_rst_a1", 64'(iss_log[1]), 64'h101);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mvu_ram_streamer.md
# mvu_ram_streamer

Read-side sequencer placed directly downstream of the simple 2-port weight/activation RAM. On a start command it walks a contiguous address range, issues one RAM read per cycle, and captures each returned word one cycle later. It buffers the words in a small FIFO and presents them to the MVU datapath as a valid/ready stream with a last-word marker. The RAM output register is overwritten every cycle whether or not `rd_en` is high, so this block must capture data on exactly the cycle after issue and must never depend on the RAM holding a word.

## Interface
- `BDADDR`, 12, RAM address width.
- `BDWORD`, 2048, RAM word width.
- `DEPTH`, 4, output FIFO depth. Legal values are powers of two and must be ≥2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: starts a transfer. Sampled only when the block is idle; ignored while `busy`.
- `base_addr` in BDADDR: first address of the transfer, sampled together with `start`.
- `length` in BDADDR+1: number of words, from 0 to 2^BDADDR, sampled together with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the transfer completes.
- `ram_rd_en` out 1: read issue strobe.
- `ram_rd_addr` out BDADDR: read address.
- `ram_rd_word` in BDWORD: RAM read data, valid exactly 1 cycle after issue.
- `out_valid` out 1, `out_ready` in 1, `out_word` out BDWORD, `out_last` out 1: output stream.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE→RUN when `start` is high and `length`≠0. `base_addr` and `length` are captured.
  - IDLE with `start` high and `length`=0: no reads are issued, `busy` stays low, and `done` pulses the next cycle.
  - RUN→DRAIN on the cycle the final read is issued.
  - DRAIN→IDLE on the cycle the word carrying `out_last` is popped (`out_valid`&&`out_ready`). `done` pulses in the cycle after that pop.
- **Read issue:** issue in RUN when `occ + inflight − pop < DEPTH`.
  - `occ` is the FIFO occupancy.
  - `inflight` is 1 if a read was issued in the previous cycle.
  - `pop` is `out_valid`&&`out_ready`.
  - This rule guarantees that a returning word always has a free FIFO slot. The FIFO never overflows, and no word is dropped.
- **Address arithmetic:** the address increments modulo 2^BDADDR, so the range wraps from 2^BDADDR−1 to 0.
  - The remaining-word counter is BDADDR+1 bits and decrements by 1 per issue.
  - `ram_rd_addr` holds its last value when no read is issued.
- **Capture:** the registered flag `inflight` pushes `ram_rd_word` into the FIFO. A push and a pop in the same cycle are both performed.
- **Last marker:** `out_last` is stored per entry. It is set on the word issued when the remaining count was 1.
- **Output:** `out_word` and `out_last` are driven from the FIFO head. They must be stable while `out_valid`&&!`out_ready`.
- **Reset:** `rst_n` low at any time, including mid-transfer, returns the block to IDLE and empties the FIFO. In-flight data is discarded.

## Timing
- **Reset values:** `busy`=0, `done`=0, `ram_rd_en`=0, `ram_rd_addr`=0, `out_valid`=0, `out_last`=0, `out_word`=0.
- **Latency:** with `start` in cycle 0, the first `ram_rd_en` is in cycle 1 and the word is pushed at the end of cycle 2. `out_valid` is high in cycle 3.
- **Throughput:** 1 word per cycle while `out_ready` is held high, for any `DEPTH`≥2.
- **Backpressure release:** after `out_ready` is deasserted, issue resumes within 1 cycle of a pop freeing a slot.

## Structure
- **Shared package `mvu_pkg`:** holds the FSM state enum (`STRM_IDLE`, `STRM_RUN`, `STRM_DRAIN`) and a default-`DEPTH` constant.
- **Sub-module `mvu_stream_fifo`:** a synchronous FIFO of width BDWORD+1 and depth `DEPTH`, with async active-low reset. It exposes `push`, `pop`, `occ`, and head data. The top level contains the FSM, counters and credit logic.

## Test plan
- **Basic transfer:** `base_addr`=0x010, `length`=8, `out_ready`=1. Expect the words of addresses 0x010–0x017 in order, `out_valid` first in cycle 3, 8 consecutive beats, `out_last` on beat 8, and `done` one cycle after it.
- **Wrap-around:** `base_addr`=0xFFE, `length`=4. Expect addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Backpressure:** `length`=16, `out_ready` toggling 1/0 at random plus a 10-cycle stall. Expect no drops or duplicates, at most `DEPTH` entries buffered, and `out_word` stable during stalls.
- **Edge lengths:**
  - `length`=0: no `ram_rd_en`, `done` one cycle after `start`.
  - `length`=1: a single beat with `out_last`=1.
  - `length`=4096: all addresses read.
- **Ignored start:** pulse `start` with different arguments while `busy`. Expect the original transfer to continue unchanged.
- **Mid-transfer reset:** assert `rst_n`=0 during beat 5 of 16. Expect all outputs at reset values immediately. Then start a new transfer with `base_addr`=0x100, `length`=2 and expect exactly 2 correct beats.
